// File: rtl/opb_slave_regbank.sv
// -----------------------------------------------------------------------------
// opb_slave_regbank
//
// OPB slave register bank. It responds to single OPB transfers that fall
// inside the [C_BASEADDR, C_HIGHADDR] window. It holds NUM_REGS 32-bit
// read/write registers with byte-enable writes. Each transfer is acknowledged
// after WAIT_STATES wait cycles. Register contents and per-register write
// strobes are exported to fabric logic.
//
// OPB bit numbering is big-endian: bit 0 is the MSB, and BE[k] qualifies
// byte k, which is DBus[8k : 8k+7].
//
// Ports
//   OPB_Clk      in   bus clock, every flop is on its rising edge
//   OPB_Rst      in   synchronous active-high reset
//   OPB_ABus     in   [0:31] transfer address
//   OPB_BE       in   [0:3]  byte enables
//   OPB_DBus     in   [0:31] write data
//   OPB_RNW      in   1 = read, 0 = write
//   OPB_select   in   master transfer valid
//   OPB_seqAddr  in   ignored; every transfer is treated as single
//   Sl_DBus      out  [0:31] read data, zero unless acking a read (OR-bus)
//   Sl_xferAck   out  one-cycle transfer acknowledge
//   Sl_errAck    out  one-cycle error acknowledge (in window, no register)
//   Sl_retry     out  tied low
//   Sl_toutSup   out  timeout suppress, high during wait cycles
//   user_regs    out  [0:32*NUM_REGS-1] register i at bits [32i : 32i+31]
//   reg_wr       out  [0:NUM_REGS-1] one-cycle pulse after register i written
// -----------------------------------------------------------------------------
module opb_slave_regbank #(
  parameter logic [31:0] C_BASEADDR  = 32'h0001_0000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0001_00FF,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [0:32*NUM_REGS-1]  user_regs,
  output logic [0:NUM_REGS-1]     reg_wr
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rnw_q, rnw_d;
  logic              valid_q, valid_d;
  logic [0:3]        be_q, be_d;
  logic              holdoff_q, holdoff_d;

  logic [0:31]          dbus_q, dbus_d;
  logic                 xfer_ack_q, xfer_ack_d;
  logic                 err_ack_q, err_ack_d;
  logic                 tout_sup_q, tout_sup_d;
  logic [0:NUM_REGS-1]  reg_wr_q, reg_wr_d;

  logic [0:31] reg_word [NUM_REGS];
  logic [0:31] rd_word;

  // ---------------------------------------------------------------------------
  // Address decode. The offset is taken on the full 32 bits, so an address
  // far into the window cannot alias back onto a low register.
  // ---------------------------------------------------------------------------
  logic [31:0] offset;
  logic [29:0] idx_full;
  logic        in_window;
  logic        hit;
  logic        idx_ok;

  assign in_window = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign hit       = OPB_select && in_window;
  assign offset    = OPB_ABus - C_BASEADDR;
  assign idx_full  = offset[31:2];
  assign idx_ok    = idx_full < 30'(NUM_REGS);

  logic unused_bits;
  assign unused_bits = ^{OPB_seqAddr, offset[1:0]};

  // The write lands on the edge that ends the ACK cycle, using the data the
  // master is still driving during ACK.
  logic commit;
  assign commit = (state_q == ST_ACK) && valid_q && !rnw_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    rnw_d   = rnw_q;
    valid_d = valid_q;
    be_d    = be_q;
    unique case (state_q)
      ST_IDLE: begin
        // Select is ignored for one cycle after ACK. The master releases it
        // on the ack edge, so a still-high select there is stale.
        if (hit && !holdoff_q) begin
          idx_d   = idx_full[IDX_W-1:0];
          rnw_d   = OPB_RNW;
          valid_d = idx_ok;
          be_d    = OPB_BE;
          wcnt_d  = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!OPB_select) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = ST_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux, indexed by the index that will be current in the ACK cycle.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_d == IDX_W'(i)) rd_word = reg_word[i];
    end
  end

  // Outputs are registered from the next state, so each one is valid during
  // the cycle its state occupies.
  always_comb begin
    xfer_ack_d = (state_d == ST_ACK) && valid_d;
    err_ack_d  = (state_d == ST_ACK) && !valid_d;
    tout_sup_d = (state_d == ST_WAIT);
    dbus_d     = ((state_d == ST_ACK) && valid_d && rnw_d) ? rd_word : '0;
    holdoff_d  = (state_q == ST_ACK);
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      idx_q      <= '0;
      rnw_q      <= 1'b0;
      valid_q    <= 1'b0;
      be_q       <= '0;
      holdoff_q  <= 1'b0;
      dbus_q     <= '0;
      xfer_ack_q <= 1'b0;
      err_ack_q  <= 1'b0;
      tout_sup_q <= 1'b0;
      reg_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      rnw_q      <= rnw_d;
      valid_q    <= valid_d;
      be_q       <= be_d;
      holdoff_q  <= holdoff_d;
      dbus_q     <= dbus_d;
      xfer_ack_q <= xfer_ack_d;
      err_ack_q  <= err_ack_d;
      tout_sup_q <= tout_sup_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: one word per generate iteration with byte-lane writes
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [0:31] word_q, word_d;
      logic        sel_wr;

      assign sel_wr = commit && (idx_q == IDX_W'(gi));

      always_comb begin
        word_d = word_q;
        if (sel_wr) begin
          for (int k = 0; k < 4; k++) begin
            if (be_q[k]) word_d[8*k +: 8] = OPB_DBus[8*k +: 8];
          end
        end
      end

      always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) word_q <= '0;
        else         word_q <= word_d;
      end

      // The strobe fires even with all byte enables low.
      assign reg_wr_d[gi]              = sel_wr;
      assign reg_word[gi]              = word_q;
      assign user_regs[32*gi +: 32]    = word_q;
    end
  endgenerate

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = xfer_ack_q;
  assign Sl_errAck  = err_ack_q;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = tout_sup_q;
  assign reg_wr     = reg_wr_q;

endmodule

// File: tb/tb_opb_slave_regbank.sv
// -----------------------------------------------------------------------------
// tb_opb_slave_regbank
//
// Directed bench for opb_slave_regbank. Two instances are used: one with one
// wait state and one with three wait states. Each has its own select line.
// Both share the rest of the bus and the reset.
// -----------------------------------------------------------------------------
module tb_opb_slave_regbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel1, sel3;
  logic        seq;

  logic [0:31]  s1_dbus, s3_dbus;
  logic         s1_ack, s1_err, s1_retry, s1_tout;
  logic         s3_ack, s3_err, s3_retry, s3_tout;
  logic [0:255] s1_regs, s3_regs;
  logic [0:7]   s1_wr, s3_wr;

  opb_slave_regbank #(.WAIT_STATES(1)) u_dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq),
    .Sl_DBus(s1_dbus), .Sl_xferAck(s1_ack), .Sl_errAck(s1_err), .Sl_retry(s1_retry),
    .Sl_toutSup(s1_tout), .user_regs(s1_regs), .reg_wr(s1_wr)
  );

  opb_slave_regbank #(.WAIT_STATES(3)) u_dut3 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel3), .OPB_seqAddr(seq),
    .Sl_DBus(s3_dbus), .Sl_xferAck(s3_ack), .Sl_errAck(s3_err), .Sl_retry(s3_retry),
    .Sl_toutSup(s3_tout), .user_regs(s3_regs), .reg_wr(s3_wr)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp1 [8];
  logic [31:0] exp3 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic sample(input int which, output logic ack, output logic err, output logic tout,
                        output logic [31:0] d, output logic [7:0] w);
    if (which == 3) begin
      ack = s3_ack; err = s3_err; tout = s3_tout; d = s3_dbus; w = s3_wr;
    end else begin
      ack = s1_ack; err = s1_err; tout = s1_tout; d = s1_dbus; w = s1_wr;
    end
  endtask

  task automatic check_regs(input int which, input string tag);
    logic [31:0] obs;
    for (int i = 0; i < 8; i++) begin
      obs = (which == 3) ? s3_regs[32*i +: 32] : s1_regs[32*i +: 32];
      check($sformatf("%s.reg%0d", tag, i), obs, (which == 3) ? exp3[i] : exp1[i]);
    end
  endtask

  // Runs one transfer. On entry the bench sits just after a rising edge. That
  // is cycle 0 of the transfer. On exit it sits two cycles after the ack.
  // Responses are looked for in cycles 1..12.
  task automatic run(input int which, input string tag, input logic [31:0] addr,
                     input logic [3:0] be_v, input logic [31:0] wd, input logic rnw_v,
                     input int exp_cyc, input logic exp_err, input logic [31:0] exp_rd,
                     input int exp_tout, input logic [7:0] exp_wr);
    logic        ack, err, tout;
    logic [31:0] d;
    logic [7:0]  w;
    logic [31:0] rdata;
    logic        was_err;
    logic [7:0]  wr_pulse;
    int          ack_cyc, tout_mask, stray;
    abus = addr; be = be_v; dbus = wd; rnw = rnw_v;
    if (which == 3) sel3 = 1'b1; else sel1 = 1'b1;
    rdata = '0; ack_cyc = -1; was_err = 1'b0; tout_mask = 0; stray = 0;
    for (int c = 1; c <= 12 && ack_cyc < 0; c++) begin
      @(posedge clk); #1;
      sample(which, ack, err, tout, d, w);
      if (tout) tout_mask |= (1 << c);
      if (w != 8'h00) stray++;
      if (ack || err) begin
        ack_cyc = c; was_err = err; rdata = d;
        if (ack && err) stray++;
      end else if (d != 32'h0) begin
        stray++;
      end
    end
    // The cycle after the ack edge: the master has released the bus.
    @(posedge clk); #1;
    sel1 = 1'b0; sel3 = 1'b0;
    sample(which, ack, err, tout, d, w);
    wr_pulse = w;
    if (ack || err || tout || d != 32'h0) stray++;
    @(posedge clk); #1;
    sample(which, ack, err, tout, d, w);
    if (ack || err || tout || d != 32'h0 || w != 8'h00) stray++;
    $display("xfer %-8s dut%0d addr=%08h rnw=%0b ack_cycle=%0d err=%0b rdata=%08h tout=%0h wr=%02h",
             tag, which, addr, rnw_v, ack_cyc, was_err, rdata, tout_mask, wr_pulse);
    check({tag, ".ackcyc"}, 32'(ack_cyc), 32'(exp_cyc));
    check({tag, ".err"},    32'(was_err), 32'(exp_err));
    check({tag, ".rdata"},  rdata, exp_rd);
    check({tag, ".tout"},   32'(tout_mask), 32'(exp_tout));
    check({tag, ".regwr"},  32'(wr_pulse), 32'(exp_wr));
    check({tag, ".stray"},  32'(stray), 32'd0);
  endtask

  int          stray;
  logic        ack, err, tout;
  logic [31:0] d;
  logic [7:0]  w;

  initial begin
    rst = 1'b1; sel1 = 1'b0; sel3 = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b1; seq = 1'b0;
    for (int i = 0; i < 8; i++) begin exp1[i] = '0; exp3[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.dbus",  s1_dbus, 32'h0);
    check("rst.ack",   32'(s1_ack), 32'd0);
    check("rst.err",   32'(s1_err), 32'd0);
    check("rst.tout",  32'(s1_tout), 32'd0);
    check("rst.retry", 32'(s1_retry), 32'd0);
    check("rst.regwr", 32'(s1_wr), 32'd0);
    check("rst.retry3", 32'(s3_retry), 32'd0);
    check_regs(1, "rst1");
    check_regs(3, "rst3");
    rst = 1'b0;
    @(posedge clk); #1;

    // One wait state: toutSup in cycle 1, ack in cycle 2
    run(1, "rd0",   32'h0001_0000, 4'hF, 32'h0, 1'b1, 2, 1'b0, 32'h0, 2, 8'h00);
    run(1, "wr1",   32'h0001_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0, 2, 8'h40);
    exp1[1] = 32'hDEAD_BEEF;
    check_regs(1, "wr1");
    run(1, "rd1",   32'h0001_0004, 4'hF, 32'h0, 1'b1, 2, 1'b0, 32'hDEAD_BEEF, 2, 8'h00);
    // Byte enables 0101 update bytes 1 and 3 only
    run(1, "wr1be", 32'h0001_0004, 4'b0101, 32'h1122_3344, 1'b0, 2, 1'b0, 32'h0, 2, 8'h40);
    exp1[1] = 32'hDE22_BE44;
    run(1, "rd1be", 32'h0001_0004, 4'hF, 32'h0, 1'b1, 2, 1'b0, 32'hDE22_BE44, 2, 8'h00);
    // Address LSBs ignored; read returns the full word even with BE=0000
    run(1, "rd1lsb", 32'h0001_0007, 4'h0, 32'h0, 1'b1, 2, 1'b0, 32'hDE22_BE44, 2, 8'h00);
    // BE=0000 write still acks and strobes, but no data changes
    run(1, "wr1be0", 32'h0001_0004, 4'h0, 32'hFFFF_FFFF, 1'b0, 2, 1'b0, 32'h0, 2, 8'h40);
    check_regs(1, "wr1be0");
    // Last implemented register
    run(1, "wr7",   32'h0001_001C, 4'hF, 32'hAABB_CCDD, 1'b0, 2, 1'b0, 32'h0, 2, 8'h01);
    exp1[7] = 32'hAABB_CCDD;
    run(1, "rd7",   32'h0001_001C, 4'hF, 32'h0, 1'b1, 2, 1'b0, 32'hAABB_CCDD, 2, 8'h00);
    // In window but beyond NUM_REGS: error ack, no write, zero data
    run(1, "wr8",   32'h0001_0020, 4'hF, 32'h1234_5678, 1'b0, 2, 1'b1, 32'h0, 2, 8'h00);
    run(1, "rd8",   32'h0001_0020, 4'hF, 32'h0, 1'b1, 2, 1'b1, 32'h0, 2, 8'h00);
    run(1, "rdtop", 32'h0001_00FF, 4'hF, 32'h0, 1'b1, 2, 1'b1, 32'h0, 2, 8'h00);
    check_regs(1, "err");
    // Outside the window: nothing is ever driven
    run(1, "wrout", 32'h0002_0000, 4'hF, 32'h5A5A_5A5A, 1'b0, -1, 1'b0, 32'h0, 0, 8'h00);
    run(1, "rdlow", 32'h0000_FFFC, 4'hF, 32'h0, 1'b1, -1, 1'b0, 32'h0, 0, 8'h00);
    check_regs(1, "out");

    // Three wait states: toutSup in cycles 1..3, ack in cycle 4
    run(3, "wr3a",  32'h0001_0008, 4'hF, 32'h0102_0304, 1'b0, 4, 1'b0, 32'h0, 14, 8'h20);
    exp3[2] = 32'h0102_0304;
    check_regs(3, "wr3a");

    // Select dropped in cycle 1 of a write: abort, no ack, no write
    abus = 32'h0001_0008; be = 4'hF; dbus = 32'h5555_5555; rnw = 1'b0; sel3 = 1'b1;
    @(posedge clk); #1;
    check("abort.tout", 32'(s3_tout), 32'd1);
    sel3 = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      sample(3, ack, err, tout, d, w);
      if (ack || err || d != 32'h0 || w != 8'h00) stray++;
    end
    $display("xfer abort    dut3 addr=00010008 rnw=0 stray=%0d", stray);
    check("abort.stray", 32'(stray), 32'd0);
    check_regs(3, "abort");
    run(3, "wr3b",  32'h0001_0008, 4'b1100, 32'hA0B0_C0D0, 1'b0, 4, 1'b0, 32'h0, 14, 8'h20);
    exp3[2] = 32'hA0B0_0304;
    run(3, "rd3b",  32'h0001_0008, 4'hF, 32'h0, 1'b1, 4, 1'b0, 32'hA0B0_0304, 14, 8'h00);

    // Reset during WAIT of a write: everything clears, no ack follows
    abus = 32'h0001_000C; be = 4'hF; dbus = 32'h1234_5678; rnw = 1'b0; sel1 = 1'b1;
    @(posedge clk); #1;
    check("rstmid.tout", 32'(s1_tout), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin exp1[i] = '0; exp3[i] = '0; end
    check("rstmid.ack",   32'(s1_ack), 32'd0);
    check("rstmid.err",   32'(s1_err), 32'd0);
    check("rstmid.toutl", 32'(s1_tout), 32'd0);
    check("rstmid.dbus",  s1_dbus, 32'h0);
    check("rstmid.regwr", 32'(s1_wr), 32'd0);
    check_regs(1, "rstmid1");
    check_regs(3, "rstmid3");
    rst = 1'b0; sel1 = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      sample(1, ack, err, tout, d, w);
      if (ack || err || tout || d != 32'h0 || w != 8'h00) stray++;
    end
    $display("xfer rstmid   dut1 addr=0001000c rnw=0 stray=%0d", stray);
    check("rstmid.stray", 32'(stray), 32'd0);
    run(1, "rdpost", 32'h0001_000C, 4'hF, 32'h0, 1'b1, 2, 1'b0, 32'h0, 2, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opb_slave_regbank.md
Name: opb_slave_regbank

Overview:
- OPB slave register bank: the responder end of the OPB transfers issued by the GPMC-to-OPB bridge master.
- Decodes an address window and holds NUM_REGS 32-bit read/write registers with byte-enable writes.
- Completes each transfer with Sl_xferAck after a programmable number of wait states.
- Exports register contents and per-register write strobes to fabric logic.

Parameters:
- C_BASEADDR, 32'h0001_0000, first byte address of the slave window (word aligned).
- C_HIGHADDR, 32'h0001_00FF, last byte address of the window (inclusive).
- NUM_REGS, 8, number of implemented 32-bit registers (1..64).
- WAIT_STATES, 1, extra cycles inserted before acknowledge (0..15).

Ports:
- OPB_Clk  in  1  bus clock; all logic on rising edge.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  transfer address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables; BE[0] qualifies DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer valid.
- OPB_seqAddr  in  1  ignored; every transfer is handled as single.
- Sl_DBus  out  [0:31]  read data; must be 0 whenever not acknowledging a read (OR-bus).
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  one-cycle error acknowledge.
- Sl_retry  out  1  constant 0.
- Sl_toutSup  out  1  timeout suppress, high while waiting.
- user_regs  out  [0:32*NUM_REGS-1]  register contents; reg i occupies bits [32*i : 32*i+31].
- reg_wr  out  [0:NUM_REGS-1]  one-cycle pulse, bit i set when reg i is written.

Behaviour:
Address decode:
- hit = OPB_select && (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
- idx = (OPB_ABus - C_BASEADDR) >> 2; the two LSBs of the address are ignored.
- valid = hit && idx < NUM_REGS.
- Outside the window the block never drives any output and stays in IDLE.

Reset (OPB_Rst=1 at an edge):
- State = IDLE; all registers = 0.
- Sl_DBus = 0; Sl_xferAck, Sl_errAck, Sl_toutSup and reg_wr all 0.
- Reset mid-transfer abandons the transfer: no ack, no write.

All outputs are registered. FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On hit, latch idx, RNW, valid and BE; load wcnt = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else to ACK.
- WAIT:
  - Sl_toutSup = 1; decrement wcnt; go to ACK when wcnt reaches 1.
  - If OPB_select = 0, abort: go to IDLE with no ack and no write.
- ACK (exactly one cycle):
  - valid: Sl_xferAck = 1.
    - Read: Sl_DBus = reg[idx], full word regardless of BE.
    - Write: reg[idx] byte k <= OPB_DBus byte k for each BE[k] = 1, committed at the end of the ACK cycle. reg_wr[idx] = 1 in the cycle following the ACK.
  - hit && !valid: Sl_errAck = 1, Sl_xferAck = 0, Sl_DBus = 0, no write.
  - Then go to IDLE.
- After ACK the block ignores OPB_select for one cycle, because the master drops select on the ack edge. A new transfer may therefore begin in the second cycle after ACK.

Timing:
- With select first seen high in cycle 0, the ack is asserted in cycle 1+WAIT_STATES.
- Sl_toutSup is high during cycles 1..WAIT_STATES.

Width rules:
- BE = 4'b0000 on a write still acks; no data changes, but the reg_wr pulse still fires.
- idx is computed on the full 32-bit subtraction, so there is no wrap-around within the window.

Test Plan:
- Reset, then read 0x0001_0000 with WAIT_STATES=1 -> toutSup high in cycle 1, xferAck and Sl_DBus=0x0000_0000 in cycle 2; Sl_DBus=0 in all other cycles.
- Write 0xDEAD_BEEF to 0x0001_0004 with BE=1111, then read it back -> read returns 0xDEAD_BEEF; reg_wr[1] pulses once; user_regs[32:63]=0xDEAD_BEEF.
- Write 0x1122_3344 with BE=0101 to 0x0001_0004 (holding 0xDEAD_BEEF) -> register reads 0xDE22_BE44.
- Access 0x0001_0020 (idx 8 ≥ NUM_REGS) -> errAck for one cycle, xferAck=0, no register changes; access 0x0002_0000 -> no output ever asserted, master-side timeout is allowed to occur.
- Drop select in cycle 1 of a write (WAIT_STATES=3) -> no ack, register unchanged; a following write completes normally.
- Assert OPB_Rst during WAIT of a write -> all outputs 0 the next cycle, registers 0; no ack is issued.
